// File: rtl/udma_apb_master_pkg.sv
// rtl/udma_apb_master_pkg.sv - shared FSM encoding and defaults for the uDMA APB requester
package udma_apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam int DEF_APB_ADDR_WIDTH = 12;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Writes never return data, so the response word is forced to zero for them.
    function automatic logic [31:0] rsp_data(input logic we, input logic [31:0] prdata);
        return we ? 32'h0 : prdata;
    endfunction

endpackage

// File: rtl/udma_apb_timeout_cnt.sv
// rtl/udma_apb_timeout_cnt.sv - saturating ACCESS-phase cycle counter with expiry flag
module udma_apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int               CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count holds completed waiting cycles, so the current cycle is the last allowed one
    // when the count has reached TIMEOUT_CYCLES-1.
    assign expired = en && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/udma_apb_master.sv
// rtl/udma_apb_master.sv - single-outstanding APB3 requester with request/response handshakes
module udma_apb_master
    import udma_apb_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = DEF_APB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    input  logic                      req_we_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    apb_state_t                r_state;
    logic                      r_req_ready;
    logic                      r_rsp_valid;
    logic [31:0]               r_rsp_rdata;
    logic                      r_rsp_err;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [31:0]               r_pwdata;
    logic                      r_pwrite;
    logic                      r_psel;
    logic                      r_penable;

    logic w_accept;
    logic w_cnt_en;
    logic w_expired;

    assign w_accept = (r_state == ST_IDLE) && req_valid_i;
    assign w_cnt_en = (r_state == ST_ACCESS) && !PREADY;

    udma_apb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr    (w_accept),
        .en     (w_cnt_en),
        .expired(w_expired)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= 32'h0;
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_paddr     <= req_addr_i;
                        r_pwdata    <= req_wdata_i;
                        r_pwrite    <= req_we_i;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY is checked first so a completion on the expiry cycle is not an error.
                    if (PREADY) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_rdata <= rsp_data(r_pwrite, PRDATA);
                        r_rsp_err   <= PSLVERR;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_expired) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PWRITE      = r_pwrite;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;

endmodule

// File: tb/tb_udma_apb_master.sv
// tb/tb_udma_apb_master.sv - directed vector bench for udma_apb_master
module tb_udma_apb_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    int          cur_waits  = 0;
    logic [31:0] cur_prdata = 32'h0;
    logic        cur_slverr = 1'b0;
    int          acc_seen   = 0;

    always #5 clk = ~clk;

    udma_apb_master #(
        .APB_ADDR_WIDTH(12),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_we_i   (req_we),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .PADDR      (paddr),
        .PWDATA     (pwdata),
        .PWRITE     (pwrite),
        .PSEL       (psel),
        .PENABLE    (penable),
        .PRDATA     (prdata),
        .PREADY     (pready),
        .PSLVERR    (pslverr)
    );

    // Completer model: ready after cur_waits wait states of the ACCESS phase.
    always @(posedge clk) begin
        if (psel && penable) acc_seen <= acc_seen + 1;
        else                 acc_seen <= 0;
    end
    assign pready  = psel && penable && (acc_seen == cur_waits);
    assign prdata  = cur_prdata;
    assign pslverr = cur_slverr;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_acc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int   setup_n = 0;
        int   acc_n = 0;
        int   lat = 0;
        int   stable_bad = 0;
        int   hold_bad = 0;
        logic got = 1'b0;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_we     = v.we;
        cur_waits  = v.waits;
        cur_prdata = v.prdata;
        cur_slverr = v.slverr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        req_we    = ~v.we;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                lat = k;
            end else begin
                if (psel && !penable) setup_n++;
                if (psel && penable) acc_n++;
                if (req_ready) stable_bad++;
                if (psel && (paddr !== v.addr || pwdata !== v.wdata || pwrite !== v.we)) stable_bad++;
            end
        end
        chk("rsp_seen", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(2 + v.exp_acc));
        chk("setup_cycles", 32'(setup_n), 32'd1);
        chk("access_cycles", 32'(acc_n), 32'(v.exp_acc));
        chk("apb_stable", 32'(stable_bad), 32'd0);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("psel_resp", 32'({psel, penable}), 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (!rsp_valid || req_ready || rsp_rdata !== v.exp_rdata || rsp_err !== v.exp_err)
                hold_bad++;
        end
        if (v.hold > 0) chk("resp_hold", 32'(hold_bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        logic got;
        // we addr wdata waits slverr prdata hold | rdata err acc
        vecs[0] = '{1'b1, 12'h084, 32'hDEADBEEF, 0,   1'b0, 32'h11112222, 0,  32'h0,        1'b0, 1};
        vecs[1] = '{1'b0, 12'h010, 32'h00000000, 3,   1'b0, 32'h12345678, 10, 32'h12345678, 1'b0, 4};
        vecs[2] = '{1'b0, 12'h0F0, 32'h5A5A5A5A, 0,   1'b1, 32'hCAFEF00D, 0,  32'hCAFEF00D, 1'b1, 1};
        vecs[3] = '{1'b0, 12'h200, 32'h00000001, 255, 1'b0, 32'hAAAA5555, 0,  32'h0,        1'b1, 4};
        vecs[4] = '{1'b1, 12'hFFC, 32'h01234567, 2,   1'b1, 32'h99999999, 0,  32'h0,        1'b1, 3};
        vecs[5] = '{1'b0, 12'h004, 32'hFFFFFFFF, 1,   1'b0, 32'h0BADF00D, 0,  32'h0BADF00D, 1'b0, 2};
        vecs[6] = '{1'b1, 12'h3A8, 32'h80000001, 3,   1'b0, 32'h77777777, 0,  32'h0,        1'b0, 4};

        rstn      = 1'b0;
        req_valid = 1'b0;
        req_addr  = 12'h0;
        req_wdata = 32'h0;
        req_we    = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_psel", 32'({psel, penable, pwrite}), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

        // A request presented during the response handshake must not be taken that cycle.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 12'h100; req_wdata = 32'h00000100; req_we = 1'b1;
        cur_waits = 0; cur_slverr = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        chk("b2b_first_rsp", 32'(got), 32'd1);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 12'h200; req_wdata = 32'h00000200; req_we = 1'b0;
        cur_prdata = 32'h00C0FFEE;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("b2b_not_taken", 32'({req_ready, psel}), 32'b10);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_taken", 32'({req_ready, psel, penable}), 32'b010);
        chk("b2b_paddr", 32'(paddr), 32'h200);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        chk("b2b_second_rdata", rsp_rdata, 32'h00C0FFEE);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset asserted in the middle of a stalled ACCESS phase.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 12'h044; req_wdata = 32'h0; req_we = 1'b0;
        cur_waits = 255;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_in_access", 32'({psel, penable}), 32'b11);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_async_drop", 32'({psel, penable}), 32'd0);
        chk("mid_paddr_clr", 32'(paddr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid || psel || !req_ready) got = 1'b1;
        end
        chk("mid_no_rsp_idle", 32'(got), 32'd0);

        run_xfer(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/udma_apb_master.md
UDMA_APB_MASTER -- requirements
Module: udma_apb_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12: width of PADDR and req_addr_i.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, legal range 1..65535: maximum ACCESS-phase cycles before forced abort.
REQ-003 SHALL have port clk_i  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_i  input  1: transfer request present.
REQ-006 SHALL have port req_ready_o  output  1: request accepted when high with req_valid_i.
REQ-007 SHALL have port req_addr_i  input  APB_ADDR_WIDTH: byte address.
REQ-008 SHALL have port req_wdata_i  input  32: write data.
REQ-009 SHALL have port req_we_i  input  1: 1 = write, 0 = read.
REQ-010 SHALL have port rsp_valid_o  output  1: response present.
REQ-011 SHALL have port rsp_ready_i  input  1: response consumed when high with rsp_valid_o.
REQ-012 SHALL have port rsp_rdata_o  output  32: read data; zero for writes and aborted transfers.
REQ-013 SHALL have port rsp_err_o  output  1: PSLVERR sampled, or timeout occurred.
REQ-014 SHALL have ports PADDR (APB_ADDR_WIDTH), PWDATA (32), PWRITE (1), PSEL (1), PENABLE (1) as outputs, and PRDATA (32), PREADY (1), PSLVERR (1) as inputs. These are the APB3 requester signals.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-016 SHALL drive req_ready_o=1 only in IDLE.
REQ-017 IDLE, accept handshake: SHALL register addr, wdata and we, and go to SETUP.
REQ-018 SETUP: SHALL drive PSEL=1 and PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-019 ACCESS: SHALL drive PSEL=1 and PENABLE=1 until PREADY=1 is sampled, then go to RESP.
REQ-020 On completion, SHALL capture rsp_rdata_o=PRDATA when reading (0 when writing) and rsp_err_o=PSLVERR.
REQ-021 SHALL hold PADDR, PWDATA and PWRITE stable from SETUP through the final ACCESS cycle; outside SETUP/ACCESS they SHALL hold their last values, with PSEL=PENABLE=0.
REQ-022 SHALL count ACCESS cycles. If the count reaches TIMEOUT_CYCLES without PREADY, it SHALL go to RESP with rsp_err_o=1 and rsp_rdata_o=0, and drop PSEL/PENABLE the next cycle.
REQ-023 If PREADY=1 arrives on the same cycle the count reaches TIMEOUT_CYCLES, PREADY SHALL win (normal completion).
REQ-024 RESP: SHALL drive rsp_valid_o=1 with rdata/err stable until rsp_ready_i=1, then return to IDLE.
REQ-025 SHALL NOT accept a new request in the same cycle as the response handshake; minimum spacing is 4 cycles per transfer.
REQ-026 Zero-wait-state latency SHALL be: accept edge, then SETUP (1 cycle), ACCESS (1 cycle), then rsp_valid_o high on the 3rd cycle after acceptance.
REQ-027 SHALL keep the timeout counter saturating and sized by $clog2(TIMEOUT_CYCLES+1); it SHALL clear on every entry to SETUP.
REQ-028 req_* changes while not in IDLE SHALL have no effect.

Reset
REQ-029 Asserting rstn_i low SHALL immediately force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, counter=0, and req_ready_o=1 after release.
REQ-030 Reset mid-transfer SHALL abandon the transfer with no response generated.

Structure
REQ-031 SHALL place the FSM state enum (2-bit encoding) and default constants in package udma_apb_master_pkg.
REQ-032 SHALL implement the timeout counter as sub-module udma_apb_timeout_cnt, with ports clr, en, expired.

Verification
REQ-033 Zero-wait write: addr 0x084, data 0xDEADBEEF, PREADY tied 1 -> PSEL 2 cycles, PENABLE 1 cycle, PWRITE=1, rsp_valid on cycle 3, err=0, rdata=0.
REQ-034 Read with 3 wait states: PRDATA=0x12345678 on the PREADY cycle -> ACCESS lasts 4 cycles, rsp_rdata_o=0x12345678, err=0.
REQ-035 PSLVERR=1 with PREADY on a read -> rsp_err_o=1 and rsp_rdata_o=PRDATA captured.
REQ-036 TIMEOUT_CYCLES=4, PREADY held 0 -> exactly 4 ACCESS cycles, rsp_err_o=1, rdata=0; then a second request completes normally.
REQ-037 rsp_ready_i held 0 for 10 cycles -> rsp_valid_o and data stable, req_ready_o=0 throughout.
REQ-038 rstn_i asserted during ACCESS -> PSEL/PENABLE drop asynchronously, no rsp_valid_o, IDLE after release.
